// File: rtl/illm_reorder_fsm_p_if.sv
// Handshake bundle for the N-lane reorder stage: joined input side (a_*),
// per-lane holding-slot output side (b_*) and the permutation select.
interface illm_reorder_fsm_p_if #(
    parameter int N = 8,
    parameter int W = 16
);
    logic [N*W-1:0] a_d;
    logic [N-1:0]   a_v;
    logic [N-1:0]   a_e;
    logic [N-1:0]   a_b;
    logic [1:0]     mode;
    logic [N*W-1:0] b_d;
    logic [N-1:0]   b_v;
    logic [N-1:0]   b_e;
    logic [N-1:0]   b_b;

    modport master (
        output a_d, a_v, a_e, mode, b_b,
        input  a_b, b_d, b_v, b_e
    );

    modport slave (
        input  a_d, a_v, a_e, mode, b_b,
        output a_b, b_d, b_v, b_e
    );
endinterface

// File: rtl/illm_reorder_fsm_p.sv
// Joint-firing N-lane stream stage: joins one token per lane, permutes lanes,
// loads N independently drained holding slots, tracks EOS alignment and counts.
module illm_reorder_fsm_p #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    illm_reorder_fsm_p_if.slave   bus,
    output logic                  statecase,
    output logic [CNT_W-1:0]      tok_count,
    output logic                  err
);
    localparam int unsigned NU = N;

    typedef enum logic [1:0] {
        S_RUN,
        S_DRAIN,
        S_ERROR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   tok_q, tok_d;
    logic               err_q, err_d;
    logic [N-1:0]       b_v_q, b_v_d;
    logic [N-1:0]       b_e_q, b_e_d;
    logic [N*W-1:0]     b_d_q, b_d_d;

    logic [N-1:0]       frees;
    logic               fire;
    logic               all_e;
    logic               no_e;
    logic               mixed;
    logic               load;
    int unsigned        src;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_RUN;
            tok_q   <= '0;
            err_q   <= 1'b0;
            b_v_q   <= '0;
            b_e_q   <= '0;
            b_d_q   <= '0;
        end else begin
            state_q <= state_d;
            tok_q   <= tok_d;
            err_q   <= err_d;
            b_v_q   <= b_v_d;
            b_e_q   <= b_e_d;
            b_d_q   <= b_d_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tok_d   = tok_q;
        err_d   = err_q;
        b_v_d   = b_v_q;
        b_e_d   = b_e_q;
        b_d_d   = b_d_q;
        src     = 0;

        for (int unsigned j = 0; j < NU; j++) begin
            if (b_v_q[j] && !bus.b_b[j]) begin
                b_v_d[j] = 1'b0;
                b_e_d[j] = 1'b0;
            end
        end

        // A load overrides the drain above, so a slot drained and refilled in
        // the same cycle keeps b_v high with no bubble.
        if (load) begin
            for (int unsigned j = 0; j < NU; j++) begin
                case (bus.mode)
                    2'd1:    src = NU - 1 - j;
                    2'd2:    src = (j % 2 == 0) ? (j / 2) : (NU - 1 - j / 2);
                    default: src = j;
                endcase
                b_d_d[j*W +: W] = bus.a_d[src*W +: W];
                b_e_d[j]        = bus.a_e[src];
                b_v_d[j]        = 1'b1;
            end
        end

        case (state_q)
            S_RUN: begin
                if (fire) begin
                    if (mixed) begin
                        err_d   = 1'b1;
                        state_d = S_ERROR;
                    end else if (all_e) begin
                        tok_d   = '0;
                        state_d = S_DRAIN;
                    end else if (tok_q != '1) begin
                        tok_d = tok_q + CNT_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (b_v_q == '0) begin
                    state_d = S_RUN;
                end
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    always_comb begin
        frees     = ~b_v_q | ~bus.b_b;
        all_e     = &bus.a_e;
        no_e      = ~|bus.a_e;
        mixed     = !all_e && !no_e;
        // Gating with reset keeps a_b all-ones for the whole reset assertion.
        fire      = reset && (state_q == S_RUN) && (&bus.a_v) && (&frees);
        load      = fire && !mixed;
        bus.a_b   = ~{N{fire}};
        statecase = load;
        bus.b_v   = b_v_q;
        bus.b_e   = b_e_q;
        bus.b_d   = b_d_q;
        tok_count = tok_q;
        err       = err_q;
    end
endmodule

// File: tb/tb_illm_reorder_fsm_p.sv
// Randomised and directed bench for illm_reorder_fsm_p against a lane-array
// reference model of the join / permute / holding-slot / EOS rules.
module tb_illm_reorder_fsm_p;
    localparam int N     = 8;
    localparam int W     = 16;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset;
    logic             statecase;
    logic [CNT_W-1:0] tok_count;
    logic             err;

    always #5 clock = ~clock;

    illm_reorder_fsm_p_if #(.N(N), .W(W)) bus();

    illm_reorder_fsm_p #(.N(N), .W(W), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .statecase (statecase),
        .tok_count (tok_count),
        .err       (err)
    );

    int checks = 0;
    int errors = 0;

    logic [W-1:0] md [N];
    bit           mv [N];
    bit           me [N];
    int           cnt;
    bit           draining;
    bit           errored;
    bit           m_err;
    bit           p_fire;
    bit           p_eos;
    bit           p_data;
    bit           p_mixed;

    task automatic check_val(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic int src_of(input int m, input int j);
        int order [N];
        for (int i = 0; i < N; i++) order[i] = i;
        if (m == 1) begin
            for (int i = 0; i < N; i++) order[i] = N - 1 - i;
        end else if (m == 2) begin
            for (int k = 0; k < N / 2; k++) begin
                order[2*k]     = k;
                order[2*k + 1] = N - 1 - k;
            end
        end
        return order[j];
    endfunction

    function automatic logic [N*W-1:0] exp_bd();
        logic [N*W-1:0] r = '0;
        for (int j = 0; j < N; j++) r[j*W +: W] = md[j];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_bv();
        logic [N-1:0] r = '0;
        for (int j = 0; j < N; j++) r[j] = mv[j];
        return r;
    endfunction

    function automatic logic [N-1:0] exp_be();
        logic [N-1:0] r = '0;
        for (int j = 0; j < N; j++) r[j] = me[j];
        return r;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < N; j++) begin
            md[j] = '0;
            mv[j] = 0;
            me[j] = 0;
        end
        cnt = 0; draining = 0; errored = 0; m_err = 0;
    endtask

    task automatic predict();
        bit all_free = 1;
        int ones = 0;
        for (int j = 0; j < N; j++) begin
            if (mv[j] && bus.b_b[j]) all_free = 0;
            if (bus.a_e[j]) ones++;
        end
        p_fire  = !draining && !errored && (bus.a_v == '1) && all_free;
        p_eos   = p_fire && ones == N;
        p_data  = p_fire && ones == 0;
        p_mixed = p_fire && !p_eos && !p_data;
    endtask

    task automatic model_step();
        bit empty_at_start = 1;
        for (int j = 0; j < N; j++) if (mv[j]) empty_at_start = 0;
        for (int j = 0; j < N; j++) begin
            if (p_eos || p_data) begin
                md[j] = bus.a_d[src_of(int'(bus.mode), j)*W +: W];
                me[j] = bus.a_e[src_of(int'(bus.mode), j)];
                mv[j] = 1;
            end else if (mv[j] && !bus.b_b[j]) begin
                mv[j] = 0;
                me[j] = 0;
            end
        end
        if (p_data) cnt = (cnt < CMAX) ? cnt + 1 : CMAX;
        else if (p_eos) begin cnt = 0; draining = 1; end
        else if (p_mixed) begin m_err = 1; errored = 1; end
        else if (draining && empty_at_start) draining = 0;
    endtask

    task automatic cycle();
        @(negedge clock);
        predict();
        check_val("a_b", N*W'(bus.a_b), N*W'({N{!p_fire}}));
        check_val("statecase", N*W'(statecase), N*W'(p_eos || p_data));
        @(posedge clock);
        #1;
        model_step();
        check_val("b_v", N*W'(bus.b_v), N*W'(exp_bv()));
        check_val("b_e", N*W'(bus.b_e), N*W'(exp_be()));
        check_val("b_d", bus.b_d, exp_bd());
        check_val("tok_count", N*W'(tok_count), N*W'(cnt));
        check_val("err", N*W'(err), N*W'(m_err));
    endtask

    task automatic set_lanes(input int base, input int step);
        for (int i = 0; i < N; i++) bus.a_d[i*W +: W] = W'(base + i * step);
    endtask

    initial begin
        logic [N*W-1:0] exp_fold;
        logic [N*W-1:0] exp_mirror;
        int guard;

        reset    = 1'b0;
        bus.a_v  = '0;
        bus.a_e  = '0;
        bus.a_d  = '0;
        bus.b_b  = '0;
        bus.mode = 2'd0;
        model_reset();
        #2;
        check_val("rst_a_b", N*W'(bus.a_b), N*W'({N{1'b1}}));
        check_val("rst_b_v", N*W'(bus.b_v), '0);
        check_val("rst_tok", N*W'(tok_count), '0);
        check_val("rst_stc", N*W'(statecase), '0);
        @(posedge clock);
        #1 reset = 1'b1;

        // identity, 4 data firings
        bus.a_v = '1;
        set_lanes(16'h1000, 1);
        for (int c = 0; c < 4; c++) cycle();
        check_val("tp_cnt4", N*W'(tok_count), N*W'(4));

        bus.mode = 2'd2;
        set_lanes(0, 16'h10);
        cycle();
        exp_fold = 128'h0040_0030_0050_0020_0060_0010_0070_0000;
        check_val("tp_fold", bus.b_d, exp_fold);
        bus.mode = 2'd1;
        cycle();
        exp_mirror = 128'h0000_0010_0020_0030_0040_0050_0060_0070;
        check_val("tp_mirror", bus.b_d, exp_mirror);

        // lane 0 missing blocks the join
        bus.mode = 2'd0;
        bus.a_v  = 8'hFE;
        cycle();
        bus.a_v  = 8'hFF;
        cycle();

        // slot 3 stalled while full
        bus.b_b = 8'h08;
        cycle();
        bus.b_b = 8'h00;
        cycle();
        check_val("tp_reload_v", N*W'(bus.b_v), N*W'(8'hFF));

        // data firings, EOS, drain and restart
        for (int c = 0; c < 5; c++) begin set_lanes(c * 16, 3); cycle(); end
        bus.a_e = '1;
        cycle();
        check_val("tp_eos_be", N*W'(bus.b_e), N*W'(8'hFF));
        check_val("tp_eos_cnt", N*W'(tok_count), '0);
        bus.a_e = '0;
        for (int c = 0; c < 4; c++) cycle();
        check_val("tp_restart_cnt", N*W'(tok_count), N*W'(2));

        // counter saturation
        for (int c = 0; c < 20; c++) cycle();
        check_val("tp_sat", N*W'(tok_count), N*W'(CMAX));

        // randomised traffic, EOS allowed but never misaligned
        for (int c = 0; c < 400; c++) begin
            bus.mode = 2'($urandom_range(0, 3));
            bus.a_v  = ($urandom_range(0, 9) < 8) ? 8'hFF : 8'($urandom);
            bus.a_e  = ($urandom_range(0, 11) == 0) ? 8'hFF : 8'h00;
            for (int i = 0; i < N; i++) begin
                bus.a_d[i*W +: W] = W'($urandom);
                bus.b_b[i]        = ($urandom_range(0, 4) == 0);
            end
            cycle();
        end

        // empty the slots, then a misaligned EOS set
        bus.a_v = '0;
        bus.a_e = '0;
        bus.b_b = '0;
        guard = 0;
        while ((draining || exp_bv() != '0) && guard < 10) begin
            cycle();
            guard++;
        end
        check_val("settle_timeout", N*W'(guard < 10), N*W'(1));
        bus.a_v = 8'hFF;
        bus.a_e = 8'h0F;
        cycle();
        check_val("tp_err", N*W'(err), N*W'(1));
        cycle();
        check_val("tp_err_ab", N*W'(bus.a_b), N*W'(8'hFF));
        check_val("tp_err_bv", N*W'(bus.b_v), '0);

        // asynchronous reset mid-cycle
        #2 reset = 1'b0;
        #1;
        check_val("arst_err", N*W'(err), '0);
        check_val("arst_b_v", N*W'(bus.b_v), '0);
        check_val("arst_a_b", N*W'(bus.a_b), N*W'(8'hFF));
        check_val("arst_tok", N*W'(tok_count), '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
